alu_slice_sequencer: RTL and testbench
======================================

// Module: alu_slice_sequencer
// PURPOSE
//  Sequences a WIDTH-bit logic/increment ALU operation over a CHUNK-bit datapath.
//  One CHUNK-wide slice is processed per clock, least significant slice first.
//  For increment, the carry ripples slice-to-slice through a carry register.
//  Sits between the operand source and the result consumer, with a valid/ready handshake on each side.
// PARAMETERS
//  WIDTH   128  operand/result width in bits; must be an integer multiple of CHUNK
//  CHUNK   32   slice width processed per cycle; NSLICE = WIDTH/CHUNK (>=1)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operation request valid
//  in_ready   out  1      block can accept a request
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B (ignored for NOT/INC)
//  in_sel     in   3      000 AND, 001 OR, 010 XOR, 011 NOT A, 1xx INC A (A+1)
//  flush      in   1      synchronous abort, returns to IDLE
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_r      out  WIDTH  result
//  out_cout   out  1      carry out of MSB (INC only; 0 for logic ops)
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset values: state=IDLE, in_ready=1, out_valid=0, out_r=0, out_cout=0, busy=0, slice idx=0, carry=0.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: in_ready=1. On in_valid&in_ready: latch a, b, sel; idx<=0; carry<=1 if sel[2] else 0; go to RUN.
//   RUN: each cycle, slice idx of out_r <= op(a[idx], b[idx]).
//     INC: {c, s} = a_slice + carry; the slice gets s and carry <= c.
//     idx++; at the last slice (idx==NSLICE-1) latch out_cout <= final carry (0 for logic ops); go to DONE.
//   DONE: out_valid=1. On out_ready go to IDLE (out_valid drops next cycle).
//  While out_valid=1, out_r and out_cout are held stable.
//  Latency: accept edge E; RUN covers edges E+1..E+NSLICE; out_valid is high after edge E+NSLICE.
//  Throughput: at most one op per NSLICE+2 cycles. in_ready is low in RUN and DONE.
//  Slices not yet written during RUN hold their previous values; only the DONE-state value is defined.
//  out_r/out_cout keep their last values after the handshake until the next op overwrites them.
//  NOT ignores in_b; INC ignores in_b. Sel values 101, 110 and 111 all behave as INC.
//  INC wrap-around: all-ones A gives out_r=0, out_cout=1.
//  Flush: synchronous and takes priority over everything; next state IDLE, out_valid=0, idx=0, carry=0.
//    out_r/out_cout are not cleared.
//    flush together with in_valid in IDLE: the request is NOT accepted.
//  rst_n low at any time (including mid-RUN): immediate return to reset values; the in-flight op is lost.
//  in_valid with in_ready=0 is ignored; the source must hold the request until accepted.
//  out_ready without out_valid has no effect.
// TESTING
//  1. AND: a=0xFF00..FF00 (128b), b=0x0FF0..0FF0 -> out_r=0x0F00..0F00, out_cout=0; out_valid 4 cycles after accept.
//  2. INC cross-slice carry: a=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF -> out_r=0x...0001_0000_0000, out_cout=0.
//  3. INC wrap: a=all ones, sel=111 -> out_r=0, out_cout=1; NOT a=0 -> all ones, out_cout=0.
//  4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_r, out_cout stable; in_ready=0 throughout.
//  5. Abort: assert rst_n=0 at RUN idx=2 -> all outputs at reset values next sample; a new op then completes correctly.
//  6. Flush: flush in RUN -> IDLE next cycle with no out_valid; flush+in_valid in IDLE -> no accept, busy stays 0.

Source files
------------

// File: rtl/alu_slice_sequencer.sv
// Slice-serial logic/increment ALU: one CHUNK-wide slice per clock, LSB slice first,
// with valid/ready handshakes on operand and result sides.
module alu_slice_sequencer #(
   parameter int WIDTH = 128,
   parameter int CHUNK = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_sel,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_r,
   output logic             out_cout,
   output logic             busy
);

   localparam int NSLICE = WIDTH / CHUNK;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_reg, state_next;
   logic [WIDTH-1:0]  a_reg, b_reg;
   logic [2:0]        sel_reg;
   logic [IDXW-1:0]   idx_reg;
   logic              carry_reg;
   logic              cout_reg;
   logic [CHUNK-1:0]  r_slice_reg [NSLICE];

   logic [CHUNK-1:0]  a_slices [NSLICE];
   logic [CHUNK-1:0]  b_slices [NSLICE];
   logic [CHUNK-1:0]  a_cur, b_cur, slice_res;
   logic [CHUNK:0]    inc_sum;
   logic              slice_carry;
   logic              last_slice;
   logic              accept;

   generate
      for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slices
         assign a_slices[gi] = a_reg[gi*CHUNK +: CHUNK];
         assign b_slices[gi] = b_reg[gi*CHUNK +: CHUNK];
         assign out_r[gi*CHUNK +: CHUNK] = r_slice_reg[gi];
      end
   endgenerate

   assign a_cur       = a_slices[idx_reg];
   assign b_cur       = b_slices[idx_reg];
   assign last_slice  = (idx_reg == IDXW'(NSLICE - 1));
   assign accept      = (state_reg == IDLE) && in_valid && !flush;

   always_comb begin
      inc_sum   = {1'b0, a_cur} + {{CHUNK{1'b0}}, carry_reg};
      slice_res = inc_sum[CHUNK-1:0];
      casez (sel_reg)
         3'b000:  slice_res = a_cur & b_cur;
         3'b001:  slice_res = a_cur | b_cur;
         3'b010:  slice_res = a_cur ^ b_cur;
         3'b011:  slice_res = ~a_cur;
         default: slice_res = inc_sum[CHUNK-1:0];
      endcase
      // Logic ops never generate a carry, so cout reads 0 for them.
      slice_carry = sel_reg[2] & inc_sum[CHUNK];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    if (in_valid)   state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state_reg == IDLE);
      out_valid = (state_reg == DONE);
      busy      = (state_reg != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg     <= '0;
         b_reg     <= '0;
         sel_reg   <= '0;
         idx_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
      end else if (flush) begin
         idx_reg   <= '0;
         carry_reg <= 1'b0;
      end else if (accept) begin
         a_reg     <= in_a;
         b_reg     <= in_b;
         sel_reg   <= in_sel;
         idx_reg   <= '0;
         carry_reg <= in_sel[2];
      end else if (state_reg == RUN) begin
         idx_reg   <= last_slice ? '0 : idx_reg + 1'b1;
         carry_reg <= slice_carry;
         if (last_slice) cout_reg <= slice_carry;
      end
   end

   // Each result slice has its own register so only the addressed slice updates.
   generate
      for (genvar gi = 0; gi < NSLICE; gi++) begin : g_result
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               r_slice_reg[gi] <= '0;
            else if (!flush && state_reg == RUN && idx_reg == IDXW'(gi))
               r_slice_reg[gi] <= slice_res;
         end
      end
   endgenerate

   assign out_cout = cout_reg;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Bench for alu_slice_sequencer: directed cases plus randomized ops scored against
// a full-width arithmetic reference.
module tb_alu_slice_sequencer;

   localparam int WIDTH  = 128;
   localparam int CHUNK  = 32;
   localparam int NSLICE = WIDTH / CHUNK;

   typedef logic [WIDTH:0] val_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [2:0]       in_sel;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_r;
   logic             out_cout;
   logic             busy;

   int checks = 0;
   int errors = 0;

   alu_slice_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sel    (in_sel),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_r     (out_r),
      .out_cout  (out_cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic val_t ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [2:0] sel);
      if (sel[2]) return val_t'(a) + val_t'(1);
      case (sel[1:0])
         2'b00:   return {1'b0, a & b};
         2'b01:   return {1'b0, a | b};
         2'b10:   return {1'b0, a ^ b};
         default: return {1'b0, ~a};
      endcase
   endfunction

   task automatic chk(input string tag, input val_t obs, input val_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  val_t'(in_ready),  val_t'(1));
      chk({tag, "_out_valid"}, val_t'(out_valid), val_t'(0));
      chk({tag, "_out_r"},     val_t'(out_r),     val_t'(0));
      chk({tag, "_out_cout"},  val_t'(out_cout),  val_t'(0));
      chk({tag, "_busy"},      val_t'(busy),      val_t'(0));
   endtask

   // Caller is at a negedge. Issues one op, checks latency, result, backpressure hold and handshake.
   task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] sel, input int hold);
      val_t exp;
      int   lat;
      int   wait_cnt;
      exp = ref_op(a, b, sel);
      wait_cnt = 0;
      while (!in_ready && wait_cnt < 20) begin
         cyc();
         wait_cnt++;
      end
      chk({tag, "_in_ready"}, val_t'(in_ready), val_t'(1));
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_sel    = sel;
      out_ready = (hold == 0);
      cyc();
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      chk({tag, "_busy_run"}, val_t'({busy, in_ready}), val_t'(2'b10));
      lat = 0;
      while (!out_valid && lat < 20) begin
         cyc();
         lat++;
      end
      chk({tag, "_latency"}, val_t'(lat), val_t'(NSLICE));
      chk({tag, "_result"}, {out_cout, out_r}, exp);
      for (int i = 0; i < hold; i++) begin
         cyc();
         chk({tag, "_hold"}, {out_valid, in_ready, out_cout, out_r}, {2'b10, exp});
      end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk({tag, "_after_hs"}, {out_valid, busy, in_ready, out_cout, out_r}, {3'b001, exp});
      $display("op %s sel=%b a=%h b=%h -> r=%h cout=%b lat=%0d", tag, sel, a, b, out_r, out_cout, lat);
   endtask

   function automatic logic [WIDTH-1:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [WIDTH-1:0] a, b;
      logic [WIDTH-1:0] saved_r;
      logic             saved_c;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sel    = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      repeat (3) cyc();
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      cyc();

      run_op("and", {4{32'hFF00_FF00}}, {4{32'h0FF0_0FF0}}, 3'b000, 0);
      chk("and_value", val_t'(out_r), val_t'({4{32'h0F00_0F00}}));
      run_op("inc_carry", 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, rand_word(), 3'b100, 1);
      chk("inc_carry_value", val_t'(out_r), val_t'(128'h0000_0000_0000_0000_0000_0001_0000_0000));
      run_op("inc_wrap", {WIDTH{1'b1}}, rand_word(), 3'b111, 0);
      chk("inc_wrap_value", {out_cout, out_r}, {1'b1, {WIDTH{1'b0}}});
      run_op("not_zero", '0, rand_word(), 3'b011, 0);
      chk("not_zero_value", {out_cout, out_r}, {1'b0, {WIDTH{1'b1}}});
      run_op("backpressure", rand_word(), rand_word(), 3'b010, 5);

      // Asynchronous reset mid-RUN at idx 2.
      in_valid = 1'b1;
      in_a     = rand_word();
      in_b     = rand_word();
      in_sel   = 3'b001;
      cyc();
      in_valid = 1'b0;
      cyc();
      cyc();
      #1 rst_n = 1'b0;
      #1 chk_reset_outputs("abort");
      cyc();
      rst_n = 1'b1;
      cyc();
      run_op("post_abort", 128'h0123_4567_89AB_CDEF_FFFF_FFFF_FFFF_FFFF, '0, 3'b101, 0);

      // Flush during RUN.
      saved_r  = out_r;
      saved_c  = out_cout;
      in_valid = 1'b1;
      in_a     = rand_word();
      in_b     = rand_word();
      in_sel   = 3'b000;
      cyc();
      in_valid = 1'b0;
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("flush_run", val_t'({busy, out_valid, in_ready}), val_t'(3'b001));
      for (int i = 0; i < NSLICE + 1; i++) begin
         cyc();
         chk("flush_no_valid", val_t'({busy, out_valid}), val_t'(2'b00));
      end
      chk("flush_keeps_cout", val_t'(out_cout), val_t'(saved_c));
      chk("flush_upper_held", val_t'(out_r[WIDTH-1:CHUNK*2]), val_t'(saved_r[WIDTH-1:CHUNK*2]));

      // Flush together with a request in IDLE must not accept it.
      flush    = 1'b1;
      in_valid = 1'b1;
      cyc();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_idle", val_t'({busy, in_ready}), val_t'(2'b01));
      cyc();
      chk("flush_idle_later", val_t'({busy, out_valid}), val_t'(2'b00));
      run_op("post_flush", rand_word(), rand_word(), 3'b110, 0);

      for (int n = 0; n < 24; n++) begin
         int mode;
         mode = int'($urandom_range(0, 3));
         a = rand_word();
         if (mode == 1) a = {WIDTH{1'b1}};
         if (mode == 2) a = {WIDTH{1'b1}} >> (CHUNK * int'($urandom_range(1, NSLICE - 1)));
         b = rand_word();
         run_op($sformatf("rand%0d", n), a, b, 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
